// File: rtl/memoria_datos_io.sv
// Data-side responder for the CPU: word RAM plus button-latch, tick-counter and status registers.
// Reads are combinational from direc; writes and all register updates happen on the rising edge.
module memoria_datos_io #(
    parameter int unsigned PROF     = 256,
    parameter int unsigned DIV_TICK = 50000,
    parameter int unsigned N_TECLAS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memWr,
    input  logic [31:0]         direc,
    input  logic [31:0]         datoOut,
    input  logic [N_TECLAS-1:0] teclas,
    output logic [31:0]         datoIn,
    output logic                irq
);

    localparam int unsigned AW = $clog2(PROF);
    localparam int unsigned PW = $clog2(DIV_TICK);

    localparam logic [31:0] ADDR_TECLAS   = 32'h0000_1000;
    localparam logic [31:0] ADDR_CONTADOR = 32'h0000_1004;
    localparam logic [31:0] ADDR_ESTADO   = 32'h0000_1008;

    logic [31:0] ram_q [PROF];

    logic [N_TECLAS-1:0] sync1_q, sync2_q, prev_q, lat_q, lat_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                tick_flag_q, tick_flag_d;
    logic                err_q, err_d;

    logic          sel_ram, sel_tec, sel_cnt, sel_est, unmapped;
    logic [AW-1:0] ram_idx;
    logic          tick;
    logic [N_TECLAS-1:0] rise, lat_clr;

    // RAM hit requires word alignment and every address bit above the RAM window clear
    assign sel_ram  = (direc[1:0] == 2'b00) && (direc[31:AW+2] == '0);
    assign sel_tec  = (direc == ADDR_TECLAS);
    assign sel_cnt  = (direc == ADDR_CONTADOR);
    assign sel_est  = (direc == ADDR_ESTADO);
    assign unmapped = !(sel_ram || sel_tec || sel_cnt || sel_est);
    assign ram_idx  = direc[AW+1:2];

    assign tick = (presc_q == PW'(DIV_TICK - 1));
    assign rise = sync2_q & ~prev_q;

    always_comb begin
        datoIn = '0;
        if (sel_ram) begin
            datoIn = ram_q[ram_idx];
        end else if (sel_tec) begin
            datoIn = {{(32-N_TECLAS){1'b0}}, lat_q};
        end else if (sel_cnt) begin
            datoIn = cnt_q;
        end else if (sel_est) begin
            datoIn = {30'b0, err_q, tick_flag_q};
        end
    end

    always_comb begin
        lat_clr = (memWr && sel_tec) ? datoOut[N_TECLAS-1:0] : '0;
        // A new edge on the same cycle as its clear keeps the bit set
        lat_d   = (lat_q & ~lat_clr) | rise;

        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = tick ? cnt_q + 32'd1 : cnt_q;
        if (memWr && sel_cnt) begin
            presc_d = '0;
            cnt_d   = datoOut;
        end

        tick_flag_d = tick_flag_q;
        if (memWr && sel_est && datoOut[0]) begin
            tick_flag_d = 1'b0;
        end
        if (tick) begin
            tick_flag_d = 1'b1;
        end

        err_d = err_q;
        if (memWr && sel_est && datoOut[1]) begin
            err_d = 1'b0;
        end
        if (memWr && unmapped) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            lat_q       <= '0;
            presc_q     <= '0;
            cnt_q       <= '0;
            tick_flag_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= teclas;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            lat_q       <= lat_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            tick_flag_q <= tick_flag_d;
            err_q       <= err_d;
        end
    end

    // RAM has no reset; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && memWr && sel_ram) begin
            ram_q[ram_idx] <= datoOut;
        end
    end

    assign irq = tick_flag_q | (|lat_q);

endmodule

// File: tb/tb_memoria_datos_io.sv
// Bench for memoria_datos_io: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the register map.
module tb_memoria_datos_io;

    localparam int unsigned PROF = 256;
    localparam int unsigned DIV  = 4;
    localparam int unsigned NT   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          memWr;
    logic [31:0]   direc;
    logic [31:0]   datoOut;
    logic [NT-1:0] teclas;
    logic [31:0]   datoIn;
    logic          irq;

    always #10 clk = ~clk;

    memoria_datos_io #(
        .PROF     (PROF),
        .DIV_TICK (DIV),
        .N_TECLAS (NT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .memWr   (memWr),
        .direc   (direc),
        .datoOut (datoOut),
        .teclas  (teclas),
        .datoIn  (datoIn),
        .irq     (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model
    logic [31:0] m_ram   [PROF];
    bit          m_ram_v [PROF];
    bit [NT-1:0] m_lat;
    bit [31:0]   m_cnt;
    int          m_presc;
    bit          m_tick;
    bit          m_err;
    bit [NT-1:0] h1, h2, h3;  // button levels sampled at the last three edges, newest first

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 4 * PROF);
    endfunction

    task automatic m_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        known = 1'b1;
        v     = 32'h0;
        if (is_ram(a)) begin
            known = m_ram_v[a / 4];
            v     = m_ram[a / 4];
        end else if (a == 32'h1000) begin
            v = 32'(m_lat);
        end else if (a == 32'h1004) begin
            v = m_cnt;
        end else if (a == 32'h1008) begin
            v = {30'b0, m_err, m_tick};
        end
    endtask

    task automatic m_reset();
        m_lat   = '0;
        m_cnt   = 0;
        m_presc = 0;
        m_tick  = 0;
        m_err   = 0;
        h1      = '0;
        h2      = '0;
        h3      = '0;
    endtask

    task automatic m_edge();
        bit          tick;
        bit [NT-1:0] rising, clr;
        bit [31:0]   n_cnt;
        int          n_presc;
        bit          n_tick, n_err;
        tick    = (m_presc == DIV - 1);
        rising  = h2 & ~h3;
        clr     = '0;
        n_presc = tick ? 0 : m_presc + 1;
        n_cnt   = tick ? m_cnt + 1 : m_cnt;
        n_tick  = m_tick;
        n_err   = m_err;
        if (memWr) begin
            if (is_ram(direc)) begin
                m_ram[direc / 4]   = datoOut;
                m_ram_v[direc / 4] = 1'b1;
            end else if (direc == 32'h1000) begin
                clr = datoOut[NT-1:0];
            end else if (direc == 32'h1004) begin
                n_cnt   = datoOut;
                n_presc = 0;
            end else if (direc == 32'h1008) begin
                if (datoOut[0]) n_tick = 0;
                if (datoOut[1]) n_err = 0;
            end else begin
                n_err = 1;
            end
        end
        if (tick) n_tick = 1;
        m_lat   = (m_lat & ~clr) | rising;
        m_cnt   = n_cnt;
        m_presc = n_presc;
        m_tick  = n_tick;
        m_err   = n_err;
        h3 = h2;
        h2 = h1;
        h1 = teclas;
    endtask

    // One cycle: compare outputs at the falling edge, advance the model at the rising edge
    task automatic step();
        logic [31:0] e;
        bit          k;
        @(negedge clk);
        m_read(direc, e, k);
        if (k) chk("datoIn", datoIn, e);
        chk("irq", 32'(irq), 32'(m_tick | (|m_lat)));
        @(posedge clk);
        if (!rst) m_edge();
        #1;
    endtask

    task automatic drv(input bit w, input logic [31:0] a, input logic [31:0] d);
        memWr   = w;
        direc   = a;
        datoOut = d;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        memWr = 1'b0;
        direc = a;
        #1;
        v = datoIn;
    endtask

    logic [31:0] v;

    initial begin
        rst = 1'b1;
        drv(0, 32'h0, 32'h0);
        teclas = '0;
        for (int i = 0; i < PROF; i++) m_ram_v[i] = 1'b0;
        m_reset();
        step();
        step();
        rst = 1'b0;

        peek(32'h1000, v); chk("rst_teclas", v, 32'h0);
        peek(32'h1004, v); chk("rst_contador", v, 32'h0);
        peek(32'h1008, v); chk("rst_estado", v, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // Tick counter cadence
        drv(0, 32'h1004, 0);
        repeat (4) step();
        peek(32'h1004, v); chk("tick1_cnt", v, 32'd1);
        peek(32'h1008, v); chk("tick1_flag", v, 32'h1);
        chk("tick1_irq", 32'(irq), 32'h1);
        drv(1, 32'h1008, 32'h1);
        step();
        peek(32'h1008, v); chk("flag_clear", v, 32'h0);
        drv(0, 32'h1004, 0);
        repeat (3) step();
        peek(32'h1004, v); chk("tick2_cnt", v, 32'd2);

        // RAM write/readback
        drv(1, 32'h8, 32'h1234_5678); step();
        drv(1, 32'h4, 32'hDEAD_BEEF); step();
        drv(1, 32'h0, 32'h1111_1111); step();
        peek(32'h4, v); chk("ram_4", v, 32'hDEAD_BEEF);
        peek(32'h8, v); chk("ram_8", v, 32'h1234_5678);
        peek(32'h1008, v); chk("ram_err", v & 32'h2, 32'h0);

        // Button latch, clear, and edge coinciding with clear
        teclas = 4'h4; drv(0, 32'h1000, 0); step();
        teclas = 4'h0; step(); step();
        peek(32'h1000, v); chk("btn_latch", v, 32'h4);
        drv(1, 32'h1000, 32'h4); step();
        peek(32'h1000, v); chk("btn_clear", v, 32'h0);
        teclas = 4'h4; drv(0, 32'h1000, 0); step(); step();
        drv(1, 32'h1000, 32'h4); step();
        peek(32'h1000, v); chk("btn_set_wins", v, 32'h4);
        drv(1, 32'h1000, 32'h4); step();
        teclas = 4'h0;
        peek(32'h1000, v); chk("btn_clear2", v, 32'h0);

        // Counter wrap and write landing on a tick
        drv(1, 32'h1004, 32'hFFFF_FFFF); step();
        drv(0, 32'h1004, 0); repeat (4) step();
        peek(32'h1004, v); chk("cnt_wrap", v, 32'h0);
        drv(1, 32'h1008, 32'h1); step();
        drv(0, 32'h1004, 0); step(); step();
        drv(1, 32'h1004, 32'h0000_A5A5); step();
        peek(32'h1004, v); chk("cnt_wr_on_tick", v, 32'h0000_A5A5);
        peek(32'h1008, v); chk("flag_on_wr_tick", v & 32'h1, 32'h1);
        drv(0, 32'h1004, 0); repeat (3) step();
        drv(1, 32'h1008, 32'h1); step();
        peek(32'h1008, v); chk("flag_set_wins", v & 32'h1, 32'h1);

        // Unmapped and misaligned writes
        drv(1, 32'h2000, 32'h0000_0BAD); step();
        peek(32'h1008, v); chk("err_unmapped", v & 32'h2, 32'h2);
        peek(32'h2000, v); chk("rd_unmapped", v, 32'h0);
        peek(32'h0, v); chk("ram_alias", v, 32'h1111_1111);
        drv(1, 32'h1008, 32'h2); step();
        peek(32'h1008, v); chk("err_clear", v & 32'h2, 32'h0);
        drv(1, 32'h0002, 32'h0000_0BAD); step();
        peek(32'h1008, v); chk("err_misalign", v & 32'h2, 32'h2);
        peek(32'h0, v); chk("ram_misalign", v, 32'h1111_1111);

        // Reset mid-count with everything set
        teclas = 4'hF; drv(0, 32'h1000, 0); repeat (3) step();
        peek(32'h1000, v); chk("pre_rst_lat", v, 32'hF);
        rst = 1'b1;
        m_reset();
        #1;
        peek(32'h1000, v); chk("async_rst_teclas", v, 32'h0);
        peek(32'h1004, v); chk("async_rst_cnt", v, 32'h0);
        peek(32'h1008, v); chk("async_rst_estado", v, 32'h0);
        chk("async_rst_irq", 32'(irq), 32'h0);
        teclas = 4'h0;
        drv(1, 32'h0, 32'h2222_2222); step();
        rst = 1'b0;
        peek(32'h0, v); chk("ram_wr_in_rst", v, 32'h1111_1111);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                m_reset();
            end else begin
                rst = 1'b0;
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: direc = 32'($urandom_range(0, 7)) << 2;
                4:          direc = 32'h1000;
                5:          direc = 32'h1004;
                6:          direc = 32'h1008;
                7:          direc = 32'h2000;
                8:          direc = 32'h1000 | 32'($urandom_range(1, 3));
                default:    direc = $urandom;
            endcase
            memWr   = ($urandom_range(0, 2) == 0);
            datoOut = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            if ($urandom_range(0, 5) == 0) teclas = NT'($urandom);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
